// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// imm_gen_pipe : RISC-V immediate decoder feeding a 2-entry valid/ready buffer
// Revision 1.0
// ============================================================================
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic            out_illegal,
  output logic [31:0]     out_inst
);

  localparam logic [2:0] c_TYPE_NONE  = 3'd0;
  localparam logic [2:0] c_TYPE_I     = 3'd1;
  localparam logic [2:0] c_TYPE_S     = 3'd2;
  localparam logic [2:0] c_TYPE_B     = 3'd3;
  localparam logic [2:0] c_TYPE_U     = 3'd4;
  localparam logic [2:0] c_TYPE_J     = 3'd5;
  localparam logic [2:0] c_TYPE_SHAMT = 3'd6;

  localparam logic [6:0] c_OP_LOAD     = 7'b0000011;
  localparam logic [6:0] c_OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] c_OP_IMM      = 7'b0010011;
  localparam logic [6:0] c_OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] c_OP_IMM_32   = 7'b0011011;
  localparam logic [6:0] c_OP_STORE    = 7'b0100011;
  localparam logic [6:0] c_OP_OP       = 7'b0110011;
  localparam logic [6:0] c_OP_LUI      = 7'b0110111;
  localparam logic [6:0] c_OP_OP_32    = 7'b0111011;
  localparam logic [6:0] c_OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] c_OP_JALR     = 7'b1100111;
  localparam logic [6:0] c_OP_JAL      = 7'b1101111;
  localparam logic [6:0] c_OP_SYSTEM   = 7'b1110011;

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  logic [6:0]      w_opcode;
  logic            w_is_shift;
  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_type;
  logic            w_illegal;

  assign w_opcode   = in_inst[6:0];
  // funct3 of 001 or 101 selects the shift forms
  assign w_is_shift = (in_inst[13:12] == 2'b01);

  always_comb begin
    w_imm     = '0;
    w_type    = c_TYPE_NONE;
    w_illegal = 1'b0;
    case (w_opcode)
      c_OP_IMM: begin
        if (w_is_shift) begin
          w_type = c_TYPE_SHAMT;
          w_imm  = (XLEN == 64) ? XLEN'(in_inst[25:20]) : XLEN'(in_inst[24:20]);
        end else begin
          w_type = c_TYPE_I;
          w_imm  = XLEN'($signed(in_inst[31:20]));
        end
      end
      c_OP_IMM_32: begin
        if (XLEN != 64) begin
          w_illegal = 1'b1;
        end else if (w_is_shift) begin
          w_type = c_TYPE_SHAMT;
          w_imm  = XLEN'(in_inst[24:20]);
        end else begin
          w_type = c_TYPE_I;
          w_imm  = XLEN'($signed(in_inst[31:20]));
        end
      end
      c_OP_LOAD, c_OP_JALR: begin
        w_type = c_TYPE_I;
        w_imm  = XLEN'($signed(in_inst[31:20]));
      end
      c_OP_STORE: begin
        w_type = c_TYPE_S;
        w_imm  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      end
      c_OP_BRANCH: begin
        w_type = c_TYPE_B;
        w_imm  = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                in_inst[11:8], 1'b0}));
      end
      c_OP_LUI, c_OP_AUIPC: begin
        w_type = c_TYPE_U;
        w_imm  = XLEN'($signed({in_inst[31:12], 12'b0}));
      end
      c_OP_JAL: begin
        w_type = c_TYPE_J;
        w_imm  = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                in_inst[30:21], 1'b0}));
      end
      c_OP_OP, c_OP_MISC_MEM, c_OP_SYSTEM: ;
      c_OP_OP_32: w_illegal = (XLEN != 64);
      default:    w_illegal = 1'b1;
    endcase
  end

  logic [1:0]      r_count;
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [XLEN-1:0] r_imm     [2];
  logic [2:0]      r_type    [2];
  logic            r_illegal [2];
  logic [31:0]     r_inst    [2];
  logic            w_push;
  logic            w_pop;

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else if (flush) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: ;
      endcase
    end
  end

  // Payload needs no reset: outputs are masked whenever the buffer is empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_imm[r_wr_ptr]     <= w_imm;
      r_type[r_wr_ptr]    <= w_type;
      r_illegal[r_wr_ptr] <= w_illegal;
      r_inst[r_wr_ptr]    <= in_inst;
    end
  end

  assign out_imm     = out_valid ? r_imm[r_rd_ptr]     : '0;
  assign out_type    = out_valid ? r_type[r_rd_ptr]    : c_TYPE_NONE;
  assign out_illegal = out_valid ? r_illegal[r_rd_ptr] : 1'b0;
  assign out_inst    = out_valid ? r_inst[r_rd_ptr]    : '0;

endmodule
`default_nettype wire
